// File: rtl/pixel_raster_stepper.sv
// pixel_raster_stepper: buffers a 24-bit RGB stream and steps a raster
// position one pixel per request pulse, presenting RGB/x/y to the slave.
// Optional feature macro: PIXEL_STEP_TESTPATTERN_EN (adds coe_pattern_sel,
// an internal 8-bar colour pattern for active pixels).
module pixel_raster_stepper #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [23:0] asi_in_data,
  input  logic        asi_in_sop,
  input  logic        asi_in_valid,
  output logic        asi_in_ready,
  input  logic        coe_request,
`ifdef PIXEL_STEP_TESTPATTERN_EN
  input  logic        coe_pattern_sel,
`endif
  output logic [7:0]  coe_red,
  output logic [7:0]  coe_green,
  output logic [7:0]  coe_blue,
  output logic [10:0] coe_x,
  output logic [10:0] coe_y,
  output logic        coe_underflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [24:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_q, count_d;
  logic          push, pop, fifo_empty;
  logic [24:0]   head;
  logic          req_q, step, at_origin;
  logic [10:0]   px_q, py_q, px_d, py_d;
  logic [23:0]   rgb_d;
  logic [10:0]   x_d, y_d;
  logic          uf_d;
  logic          pattern_on;
  logic [23:0]   pattern_rgb;

`ifdef PIXEL_STEP_TESTPATTERN_EN
  logic [2:0] bar;
  assign pattern_on = coe_pattern_sel;
  assign bar = 3'(((14'(px_q) - 14'd1) << 3) / 14'(H_ACTIVE));
  assign pattern_rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
  assign pattern_on  = 1'b0;
  assign pattern_rgb = '0;
`endif

  assign push       = asi_in_valid & asi_in_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr];
  assign step       = coe_request & ~req_q;
  assign at_origin  = (px_q == 11'd1) && (py_q == 11'd0);

  function automatic logic [10:0] adv_x(input logic [10:0] x);
    return (x >= 11'(H_TOTAL)) ? 11'd1 : x + 11'd1;
  endfunction

  function automatic logic [10:0] adv_y(input logic [10:0] x, input logic [10:0] y);
    if (x < 11'(H_TOTAL)) return y;
    return (y >= 11'(V_TOTAL - 1)) ? 11'd0 : y + 11'd1;
  endfunction

  // FIFO storage write port
  always_ff @(posedge csi_clk) begin
    if (push) mem[wr_ptr] <= {asi_in_sop, asi_in_data};
  end

  // Next-state, pop decision and output values for a detected step
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    pop     = 1'b0;
    rgb_d   = {coe_red, coe_green, coe_blue};
    x_d     = coe_x;
    y_d     = coe_y;
    uf_d    = coe_underflow;
    if (state_q == ST_SYNC && !pattern_on) begin
      if (!fifo_empty) begin
        if (head[24]) begin
          state_d = ST_RUN;
          px_d    = 11'd1;
          py_d    = 11'd0;
        end else begin
          pop = 1'b1;
        end
      end
      if (step) begin
        rgb_d = '0;
        x_d   = '0;
        y_d   = '0;
      end
    end else begin
      // Pattern mode entering from SYNC starts the raster at the line origin
      if (state_q == ST_SYNC) begin
        px_d = 11'd1;
        py_d = 11'd0;
      end
      state_d = ST_RUN;
      if (step && state_q == ST_RUN) begin
        px_d  = adv_x(px_q);
        py_d  = adv_y(px_q, py_q);
        rgb_d = '0;
        x_d   = px_q;
        y_d   = py_q;
        if (py_q >= 11'(V_ACTIVE)) begin
          x_d = '0;
        end else if (px_q > 11'(H_ACTIVE)) begin
          x_d = px_q;
        end else if (pattern_on) begin
          rgb_d = pattern_rgb;
        end else if (fifo_empty) begin
          uf_d = 1'b1;
        end else if (head[24] && !at_origin) begin
          pop   = 1'b1;
          rgb_d = head[23:0];
          x_d   = 11'd1;
          y_d   = 11'd0;
          px_d  = adv_x(11'd1);
          py_d  = adv_y(11'd1, 11'd0);
        end else if (!head[24] && at_origin) begin
          state_d = ST_SYNC;
          x_d     = '0;
          y_d     = '0;
          px_d    = px_q;
          py_d    = py_q;
        end else begin
          pop   = 1'b1;
          rgb_d = head[23:0];
        end
      end else if (step) begin
        rgb_d = '0;
        x_d   = '0;
        y_d   = '0;
      end
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  // State, position, FIFO pointers and registered outputs
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q       <= ST_SYNC;
      px_q          <= '0;
      py_q          <= '0;
      req_q         <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      asi_in_ready  <= 1'b0;
      coe_red       <= '0;
      coe_green     <= '0;
      coe_blue      <= '0;
      coe_x         <= '0;
      coe_y         <= '0;
      coe_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      py_q          <= py_d;
      req_q         <= coe_request;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q       <= count_d;
      asi_in_ready  <= (count_d != (PW+1)'(FIFO_DEPTH));
      {coe_red, coe_green, coe_blue} <= rgb_d;
      coe_x         <= x_d;
      coe_y         <= y_d;
      coe_underflow <= uf_d;
    end
  end

endmodule

// File: tb/tb_pixel_raster_stepper.sv
// Directed bench for pixel_raster_stepper. Raster geometry is scaled down
// (8 active / 12 total pixels, 3 active / 5 total lines) so full lines and
// frames stay short; the scenarios mirror the full-size ones.
module tb_pixel_raster_stepper;

  logic        csi_clk = 1'b0;
  logic        rsi_reset_n;
  logic [23:0] asi_in_data;
  logic        asi_in_sop;
  logic        asi_in_valid;
  logic        asi_in_ready;
  logic        coe_request;
  logic [7:0]  coe_red, coe_green, coe_blue;
  logic [10:0] coe_x, coe_y;
  logic        coe_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_raster_stepper #(
    .H_ACTIVE(8), .H_TOTAL(12), .V_ACTIVE(3), .V_TOTAL(5), .FIFO_DEPTH(4)
  ) dut (
    .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n),
    .asi_in_data(asi_in_data), .asi_in_sop(asi_in_sop),
    .asi_in_valid(asi_in_valid), .asi_in_ready(asi_in_ready),
    .coe_request(coe_request),
    .coe_red(coe_red), .coe_green(coe_green), .coe_blue(coe_blue),
    .coe_x(coe_x), .coe_y(coe_y), .coe_underflow(coe_underflow)
  );

  always #5 csi_clk = ~csi_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic [10:0] ex, input logic [10:0] ey,
                          input logic [23:0] rgb);
    check_val({tag, "_x"}, 32'(coe_x), 32'(ex));
    check_val({tag, "_y"}, 32'(coe_y), 32'(ey));
    check_val({tag, "_rgb"}, {8'h0, coe_red, coe_green, coe_blue}, {8'h0, rgb});
  endtask

  task automatic push_px(input logic [23:0] d, input logic s);
    int n = 0;
    @(negedge csi_clk);
    while (!asi_in_ready && n < 50) begin
      @(negedge csi_clk);
      n++;
    end
    if (n >= 50) check_val("ready_timeout", 32'(asi_in_ready), 32'd1);
    asi_in_valid = 1'b1;
    asi_in_data  = d;
    asi_in_sop   = s;
    @(negedge csi_clk);
    asi_in_valid = 1'b0;
    asi_in_sop   = 1'b0;
  endtask

  task automatic do_step();
    @(negedge csi_clk);
    coe_request = 1'b1;
    @(negedge csi_clk);
    coe_request = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rsi_reset_n  = 1'b1;
    asi_in_data  = '0;
    asi_in_sop   = 1'b0;
    asi_in_valid = 1'b0;
    coe_request  = 1'b0;
    #1 rsi_reset_n = 1'b0;
    repeat (3) @(negedge csi_clk);
    check_val("rst_ready", 32'(asi_in_ready), 32'd0);
    check_px("rst", 11'd0, 11'd0, 24'h0);
    check_val("rst_uf", 32'(coe_underflow), 32'd0);
    rsi_reset_n = 1'b1;
    @(negedge csi_clk);
    check_val("post_rst_ready", 32'(asi_in_ready), 32'd1);

    // 1: sop-led burst of three pixels, one-cycle step latency
    push_px(24'h0A0B0C, 1'b1);
    push_px(24'h112233, 1'b0);
    push_px(24'h445566, 1'b0);
    @(negedge csi_clk);
    coe_request = 1'b1;
    #1 check_val("t1_lat_x", 32'(coe_x), 32'd0);
    @(negedge csi_clk);
    coe_request = 1'b0;
    check_px("t1_p1", 11'd1, 11'd0, 24'h0A0B0C);
    do_step(); check_px("t1_p2", 11'd2, 11'd0, 24'h112233);
    do_step(); check_px("t1_p3", 11'd3, 11'd0, 24'h445566);
    check_val("t1_uf", 32'(coe_underflow), 32'd0);

    // 2: underflow at x=5, sticky afterwards
    push_px(24'h778899, 1'b0);
    do_step(); check_px("t2_p4", 11'd4, 11'd0, 24'h778899);
    check_val("t2_uf_pre", 32'(coe_underflow), 32'd0);
    do_step(); check_px("t2_p5", 11'd5, 11'd0, 24'h0);
    check_val("t2_uf", 32'(coe_underflow), 32'd1);
    do_step(); check_px("t2_p6", 11'd6, 11'd0, 24'h0);
    check_val("t2_uf_sticky", 32'(coe_underflow), 32'd1);

    // 3: end of active line, h-blank without pops, wrap to next line
    push_px(24'hA1A1A1, 1'b0);
    push_px(24'hA2A2A2, 1'b0);
    do_step(); check_px("t3_p7", 11'd7, 11'd0, 24'hA1A1A1);
    do_step(); check_px("t3_p8", 11'd8, 11'd0, 24'hA2A2A2);
    push_px(24'hB1B1B1, 1'b0);
    for (int i = 9; i <= 12; i++) begin
      do_step(); check_px($sformatf("t3_hb%0d", i), 11'(i), 11'd0, 24'h0);
    end
    do_step(); check_px("t3_l1", 11'd1, 11'd1, 24'hB1B1B1);

    // 4: finish active lines, v-blank reports x=0 without pops, frame wrap needs sop
    for (int i = 0; i < 23; i++) do_step();
    push_px(24'hC1C1C1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      do_step();
      check_px($sformatf("t4_vb%0d", i), 11'd0, (i < 12) ? 11'd3 : 11'd4, 24'h0);
    end
    do_step(); check_px("t4_nosop", 11'd0, 11'd0, 24'h0);

    // 5: non-sop beats discarded in SYNC, sop beat starts the frame
    push_px(24'hD1D1D1, 1'b0);
    push_px(24'hD2D2D2, 1'b0);
    push_px(24'hD3D3D3, 1'b0);
    push_px(24'hD4D4D4, 1'b0);
    do_step(); check_px("t5_sync", 11'd0, 11'd0, 24'h0);
    push_px(24'hE0E0E0, 1'b1);
    push_px(24'hE1E1E1, 1'b0);
    do_step(); check_px("t5_p1", 11'd1, 11'd0, 24'hE0E0E0);
    do_step(); check_px("t5_p2", 11'd2, 11'd0, 24'hE1E1E1);

    // 6: mid-line sop resyncs to the origin; async reset mid-line
    push_px(24'hF1F1F1, 1'b1);
    do_step(); check_px("t6_resync", 11'd1, 11'd0, 24'hF1F1F1);
    push_px(24'h123456, 1'b0);
    do_step(); check_px("t6_after", 11'd2, 11'd0, 24'h123456);
    push_px(24'h654321, 1'b1);
    @(negedge csi_clk);
    #2 rsi_reset_n = 1'b0;
    #1;
    check_px("t6_rst", 11'd0, 11'd0, 24'h0);
    check_val("t6_rst_uf", 32'(coe_underflow), 32'd0);
    check_val("t6_rst_ready", 32'(asi_in_ready), 32'd0);
    @(negedge csi_clk);
    rsi_reset_n = 1'b1;
    repeat (3) @(negedge csi_clk);
    check_val("t6_ready", 32'(asi_in_ready), 32'd1);
    do_step(); check_px("t6_flushed", 11'd0, 11'd0, 24'h0);
    check_val("t6_uf", 32'(coe_underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
